// File: rtl/cc_reorder_pkg.sv
// Shared types and constants for the reorder request sequencer.
package cc_reorder_pkg;

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    AR_WAIT = 1'b1
  } state_e;

  localparam int unsigned LINE_OFFSET_BITS   = 6;
  localparam int unsigned BURST_LEN_DEF      = 8;
  localparam int unsigned HIT_DATA_WIDTH_DEF = 518;
  localparam int unsigned CNT_WIDTH          = 4;
  localparam int unsigned ARLEN_WIDTH        = 4;

endpackage

// File: rtl/cc_outstanding_cnt.sv
// Outstanding miss-burst counter: saturating up/down with limit compare and
// a sticky flag for a retire arriving when nothing is in flight.
module cc_outstanding_cnt
  import cc_reorder_pkg::*;
#(
  parameter int unsigned MAX = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 inc_i,
  input  logic                 dec_i,
  output logic [CNT_WIDTH-1:0] cnt_o,
  output logic                 at_max_o,
  output logic                 err_o
);

  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 err_q, err_d;

  assign at_max_o = (cnt_q >= CNT_WIDTH'(MAX));
  assign cnt_o    = cnt_q;
  assign err_o    = err_q;

  // A retire at zero is bogus: it flags an error and never cancels an increment.
  always_comb begin
    cnt_d = cnt_q;
    err_d = err_q;
    if (dec_i && (cnt_q == '0)) begin
      err_d = 1'b1;
    end
    if (inc_i && !(dec_i && (cnt_q != '0))) begin
      if (!at_max_o) begin
        cnt_d = cnt_q + 1'b1;
      end
    end else if (dec_i && !inc_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

endmodule

// File: rtl/cc_reorder_ctrl.sv
// Request sequencer ahead of the data reorder unit: writes hit flags/data in
// request order and issues one AR burst per miss, throttled by credits and afull.
module cc_reorder_ctrl
  import cc_reorder_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH      = 32,
  parameter int unsigned HIT_DATA_WIDTH  = HIT_DATA_WIDTH_DEF,
  parameter int unsigned MAX_OUTSTANDING = 4,
  parameter int unsigned BURST_LEN       = BURST_LEN_DEF
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      lookup_valid_i,
  output logic                      lookup_ready_o,
  input  logic                      lookup_hit_i,
  input  logic [ADDR_WIDTH-1:0]     lookup_addr_i,
  input  logic [HIT_DATA_WIDTH-1:0] lookup_data_i,
  input  logic                      hit_flag_fifo_afull_i,
  output logic                      hit_flag_fifo_wren_o,
  output logic                      hit_flag_fifo_wdata_o,
  input  logic                      hit_data_fifo_afull_i,
  output logic                      hit_data_fifo_wren_o,
  output logic [HIT_DATA_WIDTH-1:0] hit_data_fifo_wdata_o,
  output logic [ADDR_WIDTH-1:0]     mem_araddr_o,
  output logic [ARLEN_WIDTH-1:0]    mem_arlen_o,
  output logic                      mem_arvalid_o,
  input  logic                      mem_arready_i,
  input  logic                      mem_rvalid_i,
  input  logic                      mem_rready_i,
  input  logic                      mem_rlast_i,
  output logic [CNT_WIDTH-1:0]      outstanding_o,
  output logic                      err_o
);

  localparam logic [ADDR_WIDTH-1:0] LINE_MASK = ADDR_WIDTH'((1 << LINE_OFFSET_BITS) - 1);

  state_e                    state_q, state_d;
  logic                      flag_wren_q, flag_wren_d;
  logic                      flag_wdata_q, flag_wdata_d;
  logic                      data_wren_q, data_wren_d;
  logic [HIT_DATA_WIDTH-1:0] data_wdata_q, data_wdata_d;
  logic                      arvalid_q, arvalid_d;
  logic [ADDR_WIDTH-1:0]     araddr_q, araddr_d;
  logic                      ready_c;
  logic                      accept_c;
  logic                      miss_accept_c;
  logic                      retire_c;
  logic                      at_max;

  // Ready never looks at lookup_valid_i, so valid has no combinational path out.
  always_comb begin
    ready_c = 1'b0;
    if ((state_q == IDLE) && !hit_flag_fifo_afull_i) begin
      ready_c = lookup_hit_i ? !hit_data_fifo_afull_i : !at_max;
    end
  end

  assign accept_c      = lookup_valid_i && ready_c;
  assign miss_accept_c = accept_c && !lookup_hit_i;
  assign retire_c      = mem_rvalid_i && mem_rready_i && mem_rlast_i;

  cc_outstanding_cnt #(
    .MAX (MAX_OUTSTANDING)
  ) u_outstanding_cnt (
    .clk      (clk),
    .rst      (rst),
    .inc_i    (miss_accept_c),
    .dec_i    (retire_c),
    .cnt_o    (outstanding_o),
    .at_max_o (at_max),
    .err_o    (err_o)
  );

  always_comb begin
    state_d      = state_q;
    flag_wren_d  = 1'b0;
    flag_wdata_d = flag_wdata_q;
    data_wren_d  = 1'b0;
    data_wdata_d = data_wdata_q;
    arvalid_d    = arvalid_q;
    araddr_d     = araddr_q;
    case (state_q)
      IDLE: begin
        if (accept_c) begin
          flag_wren_d  = 1'b1;
          flag_wdata_d = lookup_hit_i;
          if (lookup_hit_i) begin
            data_wren_d  = 1'b1;
            data_wdata_d = lookup_data_i;
          end else begin
            arvalid_d = 1'b1;
            araddr_d  = lookup_addr_i & ~LINE_MASK;
            state_d   = AR_WAIT;
          end
        end
      end
      AR_WAIT: begin
        if (mem_arready_i) begin
          arvalid_d = 1'b0;
          state_d   = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      flag_wren_q  <= 1'b0;
      flag_wdata_q <= 1'b0;
      data_wren_q  <= 1'b0;
      data_wdata_q <= '0;
      arvalid_q    <= 1'b0;
      araddr_q     <= '0;
    end else begin
      state_q      <= state_d;
      flag_wren_q  <= flag_wren_d;
      flag_wdata_q <= flag_wdata_d;
      data_wren_q  <= data_wren_d;
      data_wdata_q <= data_wdata_d;
      arvalid_q    <= arvalid_d;
      araddr_q     <= araddr_d;
    end
  end

  assign lookup_ready_o        = ready_c;
  assign hit_flag_fifo_wren_o  = flag_wren_q;
  assign hit_flag_fifo_wdata_o = flag_wdata_q;
  assign hit_data_fifo_wren_o  = data_wren_q;
  assign hit_data_fifo_wdata_o = data_wdata_q;
  assign mem_arvalid_o         = arvalid_q;
  assign mem_araddr_o          = araddr_q;
  assign mem_arlen_o           = ARLEN_WIDTH'(BURST_LEN - 1);

endmodule

// File: tb/tb_cc_reorder_ctrl.sv
// Self-checking bench for cc_reorder_ctrl: directed scenarios with literal
// expectations plus a randomized run compared against a behavioural model.
module tb_cc_reorder_ctrl;

  localparam int unsigned AW   = 32;
  localparam int unsigned HDW  = 518;
  localparam int unsigned MAXO = 4;
  localparam int unsigned BL   = 8;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic           lookup_valid_i = 1'b0;
  logic           lookup_ready_o;
  logic           lookup_hit_i = 1'b0;
  logic [AW-1:0]  lookup_addr_i = '0;
  logic [HDW-1:0] lookup_data_i = '0;
  logic           hit_flag_fifo_afull_i = 1'b0;
  logic           hit_flag_fifo_wren_o;
  logic           hit_flag_fifo_wdata_o;
  logic           hit_data_fifo_afull_i = 1'b0;
  logic           hit_data_fifo_wren_o;
  logic [HDW-1:0] hit_data_fifo_wdata_o;
  logic [AW-1:0]  mem_araddr_o;
  logic [3:0]     mem_arlen_o;
  logic           mem_arvalid_o;
  logic           mem_arready_i = 1'b0;
  logic           mem_rvalid_i = 1'b0;
  logic           mem_rready_i = 1'b0;
  logic           mem_rlast_i = 1'b0;
  logic [3:0]     outstanding_o;
  logic           err_o;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  cc_reorder_ctrl #(
    .ADDR_WIDTH      (AW),
    .HIT_DATA_WIDTH  (HDW),
    .MAX_OUTSTANDING (MAXO),
    .BURST_LEN       (BL)
  ) dut (
    .clk                   (clk),
    .rst                   (rst),
    .lookup_valid_i        (lookup_valid_i),
    .lookup_ready_o        (lookup_ready_o),
    .lookup_hit_i          (lookup_hit_i),
    .lookup_addr_i         (lookup_addr_i),
    .lookup_data_i         (lookup_data_i),
    .hit_flag_fifo_afull_i (hit_flag_fifo_afull_i),
    .hit_flag_fifo_wren_o  (hit_flag_fifo_wren_o),
    .hit_flag_fifo_wdata_o (hit_flag_fifo_wdata_o),
    .hit_data_fifo_afull_i (hit_data_fifo_afull_i),
    .hit_data_fifo_wren_o  (hit_data_fifo_wren_o),
    .hit_data_fifo_wdata_o (hit_data_fifo_wdata_o),
    .mem_araddr_o          (mem_araddr_o),
    .mem_arlen_o           (mem_arlen_o),
    .mem_arvalid_o         (mem_arvalid_o),
    .mem_arready_i         (mem_arready_i),
    .mem_rvalid_i          (mem_rvalid_i),
    .mem_rready_i          (mem_rready_i),
    .mem_rlast_i           (mem_rlast_i),
    .outstanding_o         (outstanding_o),
    .err_o                 (err_o)
  );

  task automatic chk(input string nm, input logic [HDW-1:0] act, input logic [HDW-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
  endtask

  // Behavioural model: pending AR, credit count, last FIFO writes.
  int             m_cnt;
  bit             m_err, m_pend, m_fw, m_fd, m_dw;
  logic [AW-1:0]  m_araddr;
  logic [HDW-1:0] m_dd;
  logic           exp_ready, exp_acc, r_done;

  always_comb begin
    exp_ready = !m_pend && !hit_flag_fifo_afull_i &&
                (lookup_hit_i ? !hit_data_fifo_afull_i : (m_cnt < int'(MAXO)));
    exp_acc   = lookup_valid_i && exp_ready;
    r_done    = mem_rvalid_i && mem_rready_i && mem_rlast_i;
  end

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_cnt <= 0; m_err <= 0; m_pend <= 0; m_fw <= 0; m_fd <= 0; m_dw <= 0;
      m_araddr <= '0; m_dd <= '0;
    end else begin
      m_fw <= exp_acc;
      m_dw <= exp_acc && lookup_hit_i;
      if (exp_acc) m_fd <= lookup_hit_i;
      if (exp_acc && lookup_hit_i) m_dd <= lookup_data_i;
      if (exp_acc && !lookup_hit_i) begin
        m_pend   <= 1'b1;
        m_araddr <= {lookup_addr_i[AW-1:6], 6'b0};
      end else if (mem_arready_i) begin
        m_pend <= 1'b0;
      end
      m_cnt <= m_cnt + ((exp_acc && !lookup_hit_i) ? 1 : 0) - ((r_done && m_cnt > 0) ? 1 : 0);
      if (r_done && m_cnt == 0) m_err <= 1'b1;
    end
  end

  always @(negedge clk) begin
    chk("ready",      HDW'(lookup_ready_o),        HDW'(exp_ready));
    chk("flag_wren",  HDW'(hit_flag_fifo_wren_o),  HDW'(m_fw));
    chk("flag_wdata", HDW'(hit_flag_fifo_wdata_o), HDW'(m_fd));
    chk("data_wren",  HDW'(hit_data_fifo_wren_o),  HDW'(m_dw));
    chk("data_wdata", hit_data_fifo_wdata_o,       m_dd);
    chk("arvalid",    HDW'(mem_arvalid_o),         HDW'(m_pend));
    chk("araddr",     HDW'(mem_araddr_o),          HDW'(m_araddr));
    chk("arlen",      HDW'(mem_arlen_o),           HDW'(BL - 1));
    chk("outstanding", HDW'(outstanding_o),        HDW'(m_cnt));
    chk("err",        HDW'(err_o),                 HDW'(m_err));
  end

  int hit_pulses = 0, miss_flags = 0, ar_cycles = 0;
  always @(negedge clk) begin
    if (hit_flag_fifo_wren_o && hit_flag_fifo_wdata_o) hit_pulses++;
    if (hit_flag_fifo_wren_o && !hit_flag_fifo_wdata_o) miss_flags++;
    if (mem_arvalid_o) ar_cycles++;
  end

  function automatic logic [HDW-1:0] rnd_data();
    logic [HDW-1:0] r = '0;
    for (int i = 0; i < 17; i++) r = {r[HDW-33:0], $urandom};
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input bit h, input logic [AW-1:0] a, output bit ok);
    ok = 1'b0;
    lookup_valid_i = 1'b1;
    lookup_hit_i   = h;
    lookup_addr_i  = a;
    lookup_data_i  = rnd_data();
    for (int i = 0; i < 10 && !ok; i++) begin
      @(negedge clk);
      ok = lookup_ready_o;
      step();
    end
    lookup_valid_i = 1'b0;
  endtask

  task automatic rlast_beat();
    mem_rvalid_i = 1'b1; mem_rready_i = 1'b1; mem_rlast_i = 1'b1;
    step();
    mem_rvalid_i = 1'b0; mem_rready_i = 1'b0; mem_rlast_i = 1'b0;
  endtask

  int base_hp, base_mf, base_ar;
  bit ok;

  initial begin
    #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_arvalid", HDW'(mem_arvalid_o), '0);
    chk("rst_arlen",   HDW'(mem_arlen_o), HDW'(7));
    chk("rst_out",     HDW'(outstanding_o), '0);
    chk("rst_err",     HDW'(err_o), '0);
    chk("rst_fwren",   HDW'(hit_flag_fifo_wren_o), '0);
    chk("rst_ready",   HDW'(lookup_ready_o), HDW'(1));
    step();

    // Four back-to-back hits
    base_hp = hit_pulses; base_ar = ar_cycles;
    lookup_valid_i = 1'b1; lookup_hit_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      lookup_data_i = rnd_data();
      step();
    end
    lookup_valid_i = 1'b0;
    step(); step();
    chk("hits_pulses", HDW'(hit_pulses - base_hp), HDW'(4));
    chk("hits_no_ar",  HDW'(ar_cycles - base_ar), '0);

    // Miss with arready delayed three cycles
    base_mf = miss_flags; base_ar = ar_cycles;
    lookup_valid_i = 1'b1; lookup_hit_i = 1'b0; lookup_addr_i = 32'h0000_1234;
    step();
    lookup_valid_i = 1'b0;
    @(negedge clk);
    chk("miss_araddr", HDW'(mem_araddr_o), HDW'(32'h0000_1200));
    chk("miss_arlen",  HDW'(mem_arlen_o), HDW'(7));
    chk("miss_out",    HDW'(outstanding_o), HDW'(1));
    chk("miss_ready",  HDW'(lookup_ready_o), '0);
    step(); step(); step();
    mem_arready_i = 1'b1;
    @(negedge clk);
    chk("miss_ready_arrdy", HDW'(lookup_ready_o), '0);
    step();
    mem_arready_i = 1'b0;
    step();
    chk("miss_ar_cycles", HDW'(ar_cycles - base_ar), HDW'(4));
    chk("miss_flag_once", HDW'(miss_flags - base_mf), HDW'(1));
    rlast_beat();

    // Credit limit: fifth miss stalls until one burst retires
    mem_arready_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      send(1'b0, $urandom, ok);
      chk("credit_miss_acc", HDW'(ok), HDW'(1));
    end
    lookup_valid_i = 1'b1; lookup_hit_i = 1'b0; lookup_addr_i = $urandom;
    @(negedge clk);
    chk("credit_ready_arwait", HDW'(lookup_ready_o), '0);
    step();
    @(negedge clk);
    chk("credit_ready_max", HDW'(lookup_ready_o), '0);
    chk("credit_out_max",   HDW'(outstanding_o), HDW'(4));
    step();
    mem_rvalid_i = 1'b1; mem_rready_i = 1'b1; mem_rlast_i = 1'b1;
    step();
    mem_rvalid_i = 1'b0; mem_rready_i = 1'b0; mem_rlast_i = 1'b0;
    @(negedge clk);
    chk("credit_ready_freed", HDW'(lookup_ready_o), HDW'(1));
    chk("credit_out_3",       HDW'(outstanding_o), HDW'(3));
    step();
    lookup_valid_i = 1'b0;
    @(negedge clk);
    chk("credit_out_4", HDW'(outstanding_o), HDW'(4));
    step(); step();

    // Almost-full throttling
    rlast_beat();
    lookup_valid_i = 1'b1; lookup_hit_i = 1'b1; hit_data_fifo_afull_i = 1'b1;
    @(negedge clk);
    chk("dafull_hit_stall", HDW'(lookup_ready_o), '0);
    step();
    lookup_hit_i = 1'b0;
    @(negedge clk);
    chk("dafull_miss_ok", HDW'(lookup_ready_o), HDW'(1));
    step();
    lookup_valid_i = 1'b0; hit_data_fifo_afull_i = 1'b0;
    step();
    rlast_beat();
    hit_flag_fifo_afull_i = 1'b1; lookup_valid_i = 1'b1; lookup_hit_i = 1'b1;
    @(negedge clk);
    chk("fafull_hit_stall", HDW'(lookup_ready_o), '0);
    step();
    lookup_hit_i = 1'b0;
    @(negedge clk);
    chk("fafull_miss_stall", HDW'(lookup_ready_o), '0);
    step();
    lookup_valid_i = 1'b0; hit_flag_fifo_afull_i = 1'b0;
    @(negedge clk);
    chk("fafull_out_3", HDW'(outstanding_o), HDW'(3));
    step();

    // Retire coincident with miss accept, then retire at zero
    rlast_beat();
    lookup_valid_i = 1'b1; lookup_hit_i = 1'b0;
    mem_rvalid_i = 1'b1; mem_rready_i = 1'b1; mem_rlast_i = 1'b1;
    @(negedge clk);
    chk("same_ready", HDW'(lookup_ready_o), HDW'(1));
    step();
    lookup_valid_i = 1'b0;
    mem_rvalid_i = 1'b0; mem_rready_i = 1'b0; mem_rlast_i = 1'b0;
    @(negedge clk);
    chk("same_out_2", HDW'(outstanding_o), HDW'(2));
    step();
    rlast_beat(); rlast_beat();
    @(negedge clk);
    chk("err_before", HDW'(err_o), '0);
    step();
    rlast_beat();
    @(negedge clk);
    chk("err_set", HDW'(err_o), HDW'(1));
    chk("err_out_0", HDW'(outstanding_o), '0);
    step();

    // Reset while an AR is waiting
    mem_arready_i = 1'b0;
    lookup_valid_i = 1'b1; lookup_hit_i = 1'b0; lookup_addr_i = $urandom;
    @(negedge clk);
    chk("rstar_ready", HDW'(lookup_ready_o), HDW'(1));
    step();
    lookup_valid_i = 1'b0;
    @(negedge clk);
    chk("rstar_arvalid_pre", HDW'(mem_arvalid_o), HDW'(1));
    step();
    #2 rst = 1'b1;
    #1;
    chk("rstar_arvalid_drop", HDW'(mem_arvalid_o), '0);
    chk("rstar_out_0",        HDW'(outstanding_o), '0);
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("rstar_idle_ready", HDW'(lookup_ready_o), HDW'(1));
    chk("rstar_err_clr",    HDW'(err_o), '0);
    step();

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      lookup_valid_i        = 1'($urandom % 2);
      lookup_hit_i          = 1'($urandom % 2);
      lookup_addr_i         = $urandom;
      lookup_data_i         = rnd_data();
      hit_flag_fifo_afull_i = ($urandom % 8) == 0;
      hit_data_fifo_afull_i = ($urandom % 6) == 0;
      mem_arready_i         = ($urandom % 3) != 0;
      mem_rvalid_i          = ($urandom % 3) == 0;
      mem_rready_i          = ($urandom % 4) != 0;
      mem_rlast_i           = 1'($urandom % 2);
      step();
    end
    lookup_valid_i = 1'b0; mem_rvalid_i = 1'b0;
    step(); step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
